rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
- Sequences the reorder buffer: allocates entries at the tail for in-order dispatch and marks entries done on writeback.
- Retires completed entries in order from the head.
- Squashes younger entries on a branch mispredict flush.
- Sits between dispatch/rename, the execution writeback bus and the architectural commit stage. Owns the ROB head/tail pointers, occupancy and per-entry valid/done bits.

Parameters:
- ROB_SIZE, 8, number of ROB entries; must be a power of 2, at least 2.
- ADDR_W, $clog2(ROB_SIZE), tag/pointer width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  reset, synchronous, active-low.
- disp_valid_i  in  1  dispatch requests one entry.
- disp_ready_o  out  1  entry can be allocated this cycle.
- disp_tag_o  out  ADDR_W  tag assigned to the accepted dispatch (= tail).
- wb_valid_i  in  1  execution writeback.
- wb_tag_i  in  ADDR_W  tag being completed.
- commit_valid_o  out  1  head entry is done and may retire.
- commit_tag_o  out  ADDR_W  tag at head.
- commit_ready_i  in  1  commit stage accepts the head.
- flush_i  in  1  mispredict; squash all entries younger than flush_tag_i.
- flush_tag_i  in  ADDR_W  tag of the mispredicted branch; this entry is kept.
- count_o  out  ADDR_W+1  occupancy.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == ROB_SIZE.

Behaviour:
- Reset (reset_n_i=0 at posedge): head=0, tail=0, count=0, all valid/done=0, state=RUN. Resulting outputs: disp_ready_o=1, disp_tag_o=0, commit_valid_o=0, commit_tag_o=0, count_o=0, empty_o=1, full_o=0. Reset mid-operation discards all entries the same way.
- States: RUN, FLUSH.
  - RUN -> FLUSH on an accepted flush.
  - FLUSH -> RUN unconditionally after 1 cycle.
  - In FLUSH: disp_ready_o=0, commit_valid_o=0; writebacks are still recorded.
- Dispatch:
  - disp_ready_o = (state==RUN) & !full & !flush_i.
  - On disp_valid_i & disp_ready_o: valid[tail]=1, done[tail]=0, tail=tail+1 (mod ROB_SIZE), count+1.
  - disp_tag_o is combinational = tail.
  - All ROB_SIZE entries are usable; a full ROB blocks dispatch even if a commit occurs in the same cycle.
- Writeback:
  - wb_valid_i sets done[wb_tag_i] only if valid[wb_tag_i]; otherwise it is silently ignored.
  - Takes effect the next cycle. No bypass to commit: writeback and commit eligibility for the same tag in one cycle -> commit occurs the following cycle.
- Commit:
  - commit_valid_o = (state==RUN) & valid[head] & done[head], combinational.
  - commit_tag_o = head.
  - On commit_valid_o & commit_ready_i: valid[head]=0, done[head]=0, head+1 (mod), count-1.
- Simultaneous dispatch and commit (not full): count unchanged; head and tail both advance.
- Flush:
  - Accepted only when flush_i & valid[flush_tag_i]; otherwise ignored.
  - Flush has priority: same-cycle dispatch and commit are not performed.
  - Entries from flush_tag_i+1 up to tail-1 get valid=0, done=0.
  - tail = flush_tag_i+1 (mod).
  - count = ((flush_tag_i - head) mod ROB_SIZE) + 1, computed in ADDR_W+1 bits.
- Wrap-around: pointers are ADDR_W wide and wrap naturally. Full vs empty is disambiguated only by count, never by head==tail.

Optional Feature:
- Macro: ROB_COMMIT_STATS_EN.
- When defined, adds three 32-bit saturating outputs, all reset to 0:
  - stat_full_stall_o: cycles with disp_valid_i & full.
  - stat_flush_o: accepted flushes.
  - stat_commit_o: commits.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- rob_pkg holds:
  - ROB_SIZE_DEF = 8.
  - typedef rob_tag_t (logic [ADDR_W-1:0]).
  - typedef rob_cnt_t (logic [ADDR_W:0]).
  - enum rob_ctrl_state_e {RUN, FLUSH}.
- One sub-module, rob_ptr_ctr: a modulo-ROB_SIZE pointer with increment and load inputs, instantiated for head and tail.

Test Plan:
- Reset, then 8 consecutive dispatches -> tags 0..7; full_o=1 and disp_ready_o=0 after the 8th; count_o=8.
- Writebacks for tags 2,1,0 on successive cycles with commit_ready_i=1 -> no commit until tag 0 is done. Tags 0,1,2 then commit on 3 consecutive cycles in order.
- Full ROB (head=0): writeback tag 0, then hold disp_valid_i=1 and commit_ready_i=1 -> commit tag 0, dispatch blocked that cycle, next cycle dispatch gets tag 0 (wrap); count_o returns to 8.
- 6 entries (head=0, tail=6), flush_i with flush_tag_i=2 together with disp_valid_i=1 -> no dispatch; next cycle tail=3, count_o=3, disp_ready_o=0 (FLUSH); the cycle after, disp_ready_o=1 and disp_tag_o=3.
- Writeback to a squashed tag (4 after the flush above) -> done not set; a later dispatch to tag 4 shows commit_valid_o=0 until its own writeback.
- Assert reset_n_i=0 for one cycle with 5 entries live -> count_o=0, empty_o=1, head=tail=0, commit_valid_o=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit controller: default size, tag/count widths, FSM states.
package rob_pkg;

  localparam int ROB_SIZE_DEF   = 8;
  localparam int ROB_ADDR_W_DEF = $clog2(ROB_SIZE_DEF);

  typedef logic [ROB_ADDR_W_DEF-1:0] rob_tag_t;
  typedef logic [ROB_ADDR_W_DEF:0]   rob_cnt_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_ctrl_state_e;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch / writeback / commit / flush bundle between the pipeline (master) and the ROB controller (slave).
interface rob_commit_ctrl_if #(
  parameter int ADDR_W = rob_pkg::ROB_ADDR_W_DEF
);

  logic              disp_valid_i;
  logic              disp_ready_o;
  logic [ADDR_W-1:0] disp_tag_o;
  logic              wb_valid_i;
  logic [ADDR_W-1:0] wb_tag_i;
  logic              commit_valid_o;
  logic [ADDR_W-1:0] commit_tag_o;
  logic              commit_ready_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_tag_i;
  logic [ADDR_W:0]   count_o;
  logic              empty_o;
  logic              full_o;

  modport master (
    output disp_valid_i, wb_valid_i, wb_tag_i, commit_ready_i, flush_i, flush_tag_i,
    input  disp_ready_o, disp_tag_o, commit_valid_o, commit_tag_o, count_o, empty_o, full_o
  );

  modport slave (
    input  disp_valid_i, wb_valid_i, wb_tag_i, commit_ready_i, flush_i, flush_tag_i,
    output disp_ready_o, disp_tag_o, commit_valid_o, commit_tag_o, count_o, empty_o, full_o
  );

endinterface

// File: rtl/rob_ptr_ctr.sv
// Modulo-2^ADDR_W pointer with load (priority) and increment; updates on the next posedge.
module rob_ptr_ctr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] ptr_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_o <= '0;
    end else if (load_i) begin
      ptr_o <= load_val_i;
    end else if (inc_i) begin
      ptr_o <= ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB head/tail sequencing: in-order alloc, writeback done-marking, in-order retire, flush squash.
// Status outputs are combinational off registered state; ROB_COMMIT_STATS_EN adds saturating stat counters.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int ADDR_W   = $clog2(ROB_SIZE)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  rob_commit_ctrl_if.slave   rob
`ifdef ROB_COMMIT_STATS_EN
  ,
  output logic [31:0]        stat_full_stall_o,
  output logic [31:0]        stat_flush_o,
  output logic [31:0]        stat_commit_o
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(ROB_SIZE);

  rob_ctrl_state_e      state_q;
  logic [ROB_SIZE-1:0]  valid_q, done_q, valid_d, done_d, squash_mask;
  logic [ADDR_W-1:0]    head, tail, keep_tail, squash_len;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 full, flush_acc, disp_fire, commit_fire;

  assign full        = (count_q == FULL_CNT);
  assign flush_acc   = rob.flush_i & valid_q[rob.flush_tag_i];
  assign keep_tail   = rob.flush_tag_i + 1'b1;
  assign squash_len  = tail - keep_tail;

  assign rob.disp_ready_o   = (state_q == RUN) & ~full & ~rob.flush_i;
  assign rob.disp_tag_o     = tail;
  assign rob.commit_valid_o = (state_q == RUN) & valid_q[head] & done_q[head];
  assign rob.commit_tag_o   = head;
  assign rob.count_o        = count_q;
  assign rob.empty_o        = (count_q == '0);
  assign rob.full_o         = full;

  assign disp_fire   = rob.disp_valid_i & rob.disp_ready_o;
  assign commit_fire = rob.commit_valid_o & rob.commit_ready_i & ~flush_acc;

  rob_ptr_ctr #(.ADDR_W(ADDR_W)) u_head (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (commit_fire),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (head)
  );

  rob_ptr_ctr #(.ADDR_W(ADDR_W)) u_tail (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (disp_fire),
    .load_i     (flush_acc),
    .load_val_i (keep_tail),
    .ptr_o      (tail)
  );

  // Younger entries sit at modular offsets [0, squash_len) past the kept branch.
  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      squash_mask[i] = (ADDR_W'(i) - keep_tail) < squash_len;
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (rob.wb_valid_i && valid_q[rob.wb_tag_i]) begin
      done_d[rob.wb_tag_i] = 1'b1;
    end
    if (commit_fire) begin
      valid_d[head] = 1'b0;
      done_d[head]  = 1'b0;
    end
    if (disp_fire) begin
      valid_d[tail] = 1'b1;
      done_d[tail]  = 1'b0;
    end
    if (flush_acc) begin
      valid_d = valid_d & ~squash_mask;
      done_d  = done_d & ~squash_mask;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_acc) begin
      count_d = {1'b0, rob.flush_tag_i - head} + 1'b1;
    end else if (disp_fire && !commit_fire) begin
      count_d = count_q + 1'b1;
    end else if (commit_fire && !disp_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
      valid_q <= '0;
      done_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= (state_q == RUN && flush_acc) ? FLUSH : RUN;
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

`ifdef ROB_COMMIT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stat_full_stall_o <= '0;
      stat_flush_o      <= '0;
      stat_commit_o     <= '0;
    end else begin
      if (rob.disp_valid_i && full && !(&stat_full_stall_o)) stat_full_stall_o <= stat_full_stall_o + 1'b1;
      if (flush_acc && !(&stat_flush_o))                     stat_flush_o      <= stat_flush_o + 1'b1;
      if (commit_fire && !(&stat_commit_o))                  stat_commit_o     <= stat_commit_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: expected dispatch/commit tags queued by stimulus, popped by a negedge monitor.
module tb_rob_commit_ctrl;
  import rob_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rob_commit_ctrl_if #(.ADDR_W(AW)) rob ();

`ifdef ROB_COMMIT_STATS_EN
  logic [31:0] s_stall, s_flush, s_commit;
`endif

  rob_commit_ctrl #(.ROB_SIZE(N)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .rob       (rob)
`ifdef ROB_COMMIT_STATS_EN
    ,
    .stat_full_stall_o (s_stall),
    .stat_flush_o      (s_flush),
    .stat_commit_o     (s_commit)
`endif
  );

  int errs = 0;
  int chks = 0;
  logic [AW-1:0] exp_commit_q[$];
  logic [AW-1:0] exp_disp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (reset_n_i && rob.commit_valid_o && rob.commit_ready_i) begin
      if (exp_commit_q.size() == 0) begin
        chks++; errs++;
        $display("FAIL commit_unexpected: got tag %0d expected none", rob.commit_tag_o);
      end else begin
        check("commit_tag", 32'(rob.commit_tag_o), 32'(exp_commit_q.pop_front()));
      end
    end
    if (reset_n_i && rob.disp_valid_i && rob.disp_ready_o) begin
      if (exp_disp_q.size() == 0) begin
        chks++; errs++;
        $display("FAIL disp_unexpected: got tag %0d expected none", rob.disp_tag_o);
      end else begin
        check("disp_tag", 32'(rob.disp_tag_o), 32'(exp_disp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rob.disp_valid_i   = 1'b0;
    rob.wb_valid_i     = 1'b0;
    rob.wb_tag_i       = '0;
    rob.commit_ready_i = 1'b0;
    rob.flush_i        = 1'b0;
    rob.flush_tag_i    = '0;
    repeat (2) cyc();
    reset_n_i = 1'b1;

    @(negedge clk_i);
    check("rst_count", 32'(rob.count_o), 0);
    check("rst_empty", 32'(rob.empty_o), 1);
    check("rst_full", 32'(rob.full_o), 0);
    check("rst_disp_ready", 32'(rob.disp_ready_o), 1);
    check("rst_disp_tag", 32'(rob.disp_tag_o), 0);
    check("rst_commit_valid", 32'(rob.commit_valid_o), 0);
    check("rst_commit_tag", 32'(rob.commit_tag_o), 0);
    cyc();

    // Fill all eight entries.
    rob.disp_valid_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_disp_q.push_back(AW'(i));
      cyc();
    end
    rob.disp_valid_i = 1'b0;
    @(negedge clk_i);
    check("fill_count", 32'(rob.count_o), 8);
    check("fill_full", 32'(rob.full_o), 1);
    check("fill_disp_ready", 32'(rob.disp_ready_o), 0);
    check("fill_empty", 32'(rob.empty_o), 0);
    cyc();

    // Full ROB: commit of tag 0 does not free a slot for a same-cycle dispatch.
    rob.wb_valid_i = 1'b1; rob.wb_tag_i = 3'd0; rob.commit_ready_i = 1'b1;
    @(negedge clk_i);
    check("wrap_cv_before_wb", 32'(rob.commit_valid_o), 0);
    cyc();
    rob.wb_valid_i = 1'b0; rob.disp_valid_i = 1'b1;
    exp_commit_q.push_back(3'd0);
    @(negedge clk_i);
    check("wrap_disp_blocked", 32'(rob.disp_ready_o), 0);
    check("wrap_cv", 32'(rob.commit_valid_o), 1);
    cyc();
    exp_disp_q.push_back(3'd0);
    @(negedge clk_i);
    check("wrap_count_mid", 32'(rob.count_o), 7);
    check("wrap_disp_ready", 32'(rob.disp_ready_o), 1);
    cyc();
    rob.disp_valid_i = 1'b0;
    @(negedge clk_i);
    check("wrap_count", 32'(rob.count_o), 8);
    check("wrap_full", 32'(rob.full_o), 1);
    check("wrap_head", 32'(rob.commit_tag_o), 1);
    cyc();

    // Out-of-order writebacks 3,2,1: nothing retires until the head is done.
    rob.wb_valid_i = 1'b1; rob.wb_tag_i = 3'd3;
    cyc();
    rob.wb_tag_i = 3'd2;
    @(negedge clk_i);
    check("ooo_cv_a", 32'(rob.commit_valid_o), 0);
    cyc();
    rob.wb_tag_i = 3'd1;
    @(negedge clk_i);
    check("ooo_cv_b", 32'(rob.commit_valid_o), 0);
    cyc();
    rob.wb_valid_i = 1'b0;
    exp_commit_q.push_back(3'd1);
    exp_commit_q.push_back(3'd2);
    exp_commit_q.push_back(3'd3);
    @(negedge clk_i);
    check("ooo_cv_c", 32'(rob.commit_valid_o), 1);
    repeat (3) cyc();
    rob.commit_ready_i = 1'b0;
    @(negedge clk_i);
    check("ooo_count", 32'(rob.count_o), 5);
    check("ooo_cv_after", 32'(rob.commit_valid_o), 0);
    check("ooo_head", 32'(rob.commit_tag_o), 4);
    cyc();

    // Reset with five live entries, head done.
    rob.wb_valid_i = 1'b1; rob.wb_tag_i = 3'd4;
    cyc();
    rob.wb_valid_i = 1'b0;
    @(negedge clk_i);
    check("mrst_cv_pre", 32'(rob.commit_valid_o), 1);
    cyc();
    reset_n_i = 1'b0;
    cyc();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("mrst_count", 32'(rob.count_o), 0);
    check("mrst_empty", 32'(rob.empty_o), 1);
    check("mrst_cv", 32'(rob.commit_valid_o), 0);
    check("mrst_head", 32'(rob.commit_tag_o), 0);
    check("mrst_tail", 32'(rob.disp_tag_o), 0);
    cyc();

    // Six entries, then flush at tag 2 with a competing dispatch.
    rob.disp_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_disp_q.push_back(AW'(i));
      cyc();
    end
    rob.flush_i = 1'b1; rob.flush_tag_i = 3'd2;
    @(negedge clk_i);
    check("fl_disp_blocked", 32'(rob.disp_ready_o), 0);
    cyc();
    rob.flush_i = 1'b0; rob.disp_valid_i = 1'b0;
    rob.wb_valid_i = 1'b1; rob.wb_tag_i = 3'd4;
    @(negedge clk_i);
    check("fl_count", 32'(rob.count_o), 3);
    check("fl_disp_ready", 32'(rob.disp_ready_o), 0);
    check("fl_tail", 32'(rob.disp_tag_o), 3);
    check("fl_cv", 32'(rob.commit_valid_o), 0);
    cyc();
    rob.wb_valid_i = 1'b0; rob.disp_valid_i = 1'b1;
    exp_disp_q.push_back(3'd3);
    @(negedge clk_i);
    check("fl_ready_back", 32'(rob.disp_ready_o), 1);
    check("fl_tag_back", 32'(rob.disp_tag_o), 3);
    cyc();
    exp_disp_q.push_back(3'd4);
    cyc();
    rob.disp_valid_i = 1'b0;

    // Retire 0..3; the re-dispatched tag 4 must wait for its own writeback.
    rob.commit_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) exp_commit_q.push_back(AW'(i));
    rob.wb_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rob.wb_tag_i = AW'(i);
      cyc();
    end
    rob.wb_valid_i = 1'b0;
    repeat (2) cyc();
    @(negedge clk_i);
    check("sq_cv", 32'(rob.commit_valid_o), 0);
    check("sq_head", 32'(rob.commit_tag_o), 4);
    check("sq_count", 32'(rob.count_o), 1);
    cyc();
    rob.wb_valid_i = 1'b1; rob.wb_tag_i = 3'd4;
    exp_commit_q.push_back(3'd4);
    cyc();
    rob.wb_valid_i = 1'b0;
    cyc();
    rob.commit_ready_i = 1'b0;
    @(negedge clk_i);
    check("end_count", 32'(rob.count_o), 0);
    check("end_empty", 32'(rob.empty_o), 1);
    check("commit_q_left", 32'(exp_commit_q.size()), 0);
    check("disp_q_left", 32'(exp_disp_q.size()), 0);
`ifdef ROB_COMMIT_STATS_EN
    check("stat_flush", s_flush, 1);
    check("stat_commit", s_commit, 5);
    check("stat_full_stall", s_stall, 0);
`endif
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
